// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a jk flop: buffers hold/clear/set/toggle requests and
// replays each as a one-cycle J/K pulse plus a dwell gap. Optional Q checker: JK_SEQ_CHECK_EN.
module jk_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DWELL_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd,
    input  logic [DWELL_W-1:0]         dwell,
    output logic                       j,
    output logic                       k,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       q_fb,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [1:0]         cmd;
        logic [DWELL_W-1:0] dwell;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    entry_t               mem [DEPTH];
    entry_t               head;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level_next;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic                 take;

    state_t               state;
    state_t               state_next;
    logic [DWELL_W-1:0]   cnt;
    logic [DWELL_W-1:0]   cnt_next;
    logic                 j_next;
    logic                 k_next;

    assign push       = cmd_valid && cmd_ready;
    assign empty      = (level == LW'(0));
    assign head       = mem[rd_ptr];
    assign level_next = level + LW'(push) - LW'(pop);

    // FIFO storage; pointers reset separately so contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{cmd: cmd, dwell: dwell};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            busy      <= 1'b0;
            level     <= '0;
            cmd_ready <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            j         <= j_next;
            k         <= k_next;
            level     <= level_next;
            cmd_ready <= (level_next != LW'(DEPTH));
            busy      <= (state_next != S_IDLE) || (level_next != LW'(0));
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // take: this edge may start the next command (IDLE, end of dwell, or zero-dwell APPLY)
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        j_next     = 1'b0;
        k_next     = 1'b0;
        pop        = 1'b0;
        take       = 1'b0;
        case (state)
            S_IDLE: begin
                take = 1'b1;
            end
            S_APPLY: begin
                if (cnt != DWELL_W'(0)) begin
                    state_next = S_DWELL;
                end else begin
                    take = 1'b1;
                end
            end
            S_DWELL: begin
                if (cnt == DWELL_W'(1)) begin
                    take = 1'b1;
                end else begin
                    cnt_next = cnt - DWELL_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (take) begin
            if (!empty) begin
                pop        = 1'b1;
                state_next = S_APPLY;
                j_next     = head.cmd[1];
                k_next     = head.cmd[0];
                cnt_next   = head.dwell;
            end else begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic exp_q;
    logic chk_pend;
    logic err_q;

    // exp_q follows the flop at the sampling edge; q_fb is compared one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q    <= 1'b0;
            chk_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chk_pend <= (state == S_APPLY);
            if (state == S_APPLY) begin
                case ({j, k})
                    2'b10:   exp_q <= 1'b1;
                    2'b01:   exp_q <= 1'b0;
                    2'b11:   exp_q <= ~exp_q;
                    default: exp_q <= exp_q;
                endcase
            end
            if (chk_pend && (q_fb != exp_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: vector table plus hand-written full/wrap,
// async-reset and (when JK_SEQ_CHECK_EN is defined) checker sequences.
module tb_jk_cmd_sequencer;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [3:0] dwell;
    logic       j;
    logic       k;
    logic       busy;
    logic [2:0] level;
    logic       q_fb;
    logic       err;

    logic       q_model;
    logic       force_low;

    int n_cmp;
    int n_bad;

    jk_cmd_sequencer #(.DEPTH(4), .DWELL_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .dwell     (dwell),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .level     (level),
        .q_fb      (q_fb),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference jk flop on the same clock and reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_model <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   q_model <= 1'b1;
                2'b01:   q_model <= 1'b0;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end
    assign q_fb = q_model & ~force_low;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [3:0] d;
        logic       ej;
        logic       ek;
        logic       erdy;
        logic       ebusy;
        logic [2:0] elvl;
    } vec_t;

    vec_t tbl [12];

    logic [1:0] wcmds [6];

    initial begin
        int pi;
        int qi;
        int last;
        int prev_level;
        int prev_push;
        int pulses;
        logic saw_full;
        logic pulse;

        n_cmp = 0;
        n_bad = 0;
        force_low = 1'b0;

        // inputs driven this step; outputs expected after the edge that opened this step
        tbl[0]  = '{1'b1, 2'b10, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[5]  = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[8]  = '{1'b1, 2'b01, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
        tbl[9]  = '{1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1};
        tbl[10] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[11] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};

        wcmds[0] = 2'b10; wcmds[1] = 2'b01; wcmds[2] = 2'b11;
        wcmds[3] = 2'b10; wcmds[4] = 2'b01; wcmds[5] = 2'b11;

        // reset held for 3 cycles
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        dwell     = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_j", int'(j), 0);
        chk("rst_k", int'(k), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);

        // single set with dwell 2, then toggle/toggle/clear back-to-back
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            cmd_valid = tbl[i].v;
            cmd       = tbl[i].c;
            dwell     = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_j", i), int'(j), int'(tbl[i].ej));
            chk($sformatf("vec%0d_k", i), int'(k), int'(tbl[i].ek));
            chk($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(tbl[i].erdy));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].ebusy));
            chk($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].elvl));
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        // full/wrap: 6 commands, dwell 3, cmd_valid held while any remain
        pi = 0; qi = 0; last = -1; prev_level = 0; prev_push = 0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk);
            #1;
            pulse = j | k;
            if (cyc > 0) chk("wrap_level", int'(level), prev_level + prev_push - int'(pulse));
            chk("wrap_ready", int'(cmd_ready), (level != 3'd4) ? 1 : 0);
            if (level == 3'd4) saw_full = 1'b1;
            if (pulse) begin
                if (qi < 6) chk($sformatf("wrap_jk%0d", qi), int'({j, k}), int'(wcmds[qi]));
                if (qi > 0) chk("wrap_spacing", cyc - last, 4);
                last = cyc;
                qi++;
            end
            if (pi < 6) begin
                cmd_valid = 1'b1;
                cmd       = wcmds[pi];
                dwell     = 4'd3;
            end else begin
                cmd_valid = 1'b0;
            end
            prev_push  = (cmd_valid && cmd_ready) ? 1 : 0;
            if (prev_push == 1) pi++;
            prev_level = int'(level);
        end
        cmd_valid = 1'b0;
        chk("wrap_saw_full", int'(saw_full), 1);
        chk("wrap_pushed", pi, 6);
        chk("wrap_pulses", qi, 6);
        chk("wrap_busy_end", int'(busy), 0);

        // async reset during DWELL with two entries queued
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd       = wcmds[n];
            dwell     = 4'd3;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("mid_level_pre", int'(level), 2);
        chk("mid_busy_pre", int'(busy), 1);
        chk("mid_jk_pre", int'({j, k}), 0);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_jk", int'({j, k}), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (j | k) pulses++;
        end
        chk("mid_no_pulses", pulses, 0);
        chk("mid_busy_post", int'(busy), 0);
        chk("mid_level_post", int'(level), 0);

`ifdef JK_SEQ_CHECK_EN
        // set, toggle, toggle with the reference flop attached: no error
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            cmd       = (n == 0) ? 2'b10 : 2'b11;
            dwell     = 4'd0;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("chk_err_clean", int'(err), 0);
        force_low = 1'b1;
        cmd_valid = 1'b1;
        cmd       = 2'b10;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("chk_err_e2", int'(err), 0);
        @(posedge clk);
        #1 chk("chk_err_e3", int'(err), 1);
        force_low = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("chk_err_sticky", int'(err), 1);
`else
        repeat (2) @(posedge clk);
        #1 chk("err_tied_low", int'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Upstream command stage for the `jk` flip-flop: it accepts hold, clear, set and toggle requests over a valid/ready handshake and buffers them in a small FIFO. It replays each request as a single-cycle J/K pulse followed by a programmable idle (dwell) interval. Its `j`/`k` outputs connect directly to the `jk` flop's J and K inputs, which share `clk`. An optional checker models the expected flop output and flags mismatches on `q_fb`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DWELL_W`, 4: width of the per-command dwell field.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous reset, active-low.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd` in 2: command code; 00 = hold (J=0, K=0), 01 = clear (J=0, K=1), 10 = set (J=1, K=0), 11 = toggle (J=1, K=1).
- `dwell` in DWELL_W: number of idle cycles inserted after this command's pulse.
- `j` out 1: registered J drive to the flop.
- `k` out 1: registered K drive to the flop.
- `busy` out 1: high when FSM is not IDLE or the FIFO is non-empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `q_fb` in 1: flop Q, fed back for checking.
- `err` out 1: sticky mismatch flag.

## Operation
- Reset values:
  - `j` = `k` = 0.
  - `cmd_ready` = 1.
  - `busy` = 0.
  - `level` = 0.
  - `err` = 0.
  - FIFO is empty.
  - FSM is in IDLE.
- Push:
  - A push occurs on a rising edge with `cmd_valid` && `cmd_ready`; it stores {`cmd`, `dwell`}.
  - When full, `cmd_ready` = 0 and `cmd_valid` is ignored.
  - A pop in the same cycle does not free a slot for that cycle's push.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - `level` increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- FSM states: IDLE, APPLY, DWELL.
  - IDLE: if FIFO is non-empty, pop the head, load `j`/`k` from `cmd`, load the dwell counter, and go to APPLY. Otherwise `j` = `k` = 0.
  - APPLY (exactly 1 cycle, `j`/`k` = command):
    - If dwell ≠ 0: next state is DWELL and `j` = `k` = 0.
    - Else if FIFO is non-empty: pop the next entry and stay in APPLY (back-to-back pulses).
    - Else: go to IDLE.
  - DWELL: `j` = `k` = 0 and the counter decrements each cycle. On the edge where the counter equals 1, behave as IDLE (pop and APPLY if non-empty, else IDLE).
- Command spacing is exactly 1 + dwell cycles. A hold command still consumes its pulse and dwell cycles.
- Asynchronous reset mid-operation:
  - Outputs return to reset values immediately.
  - FIFO contents are discarded.
  - Any in-flight pulse is truncated.

## Timing
- Latency from push at edge E into an empty, IDLE block: `j`/`k` are valid from edge E+1 to edge E+2. The `jk` flop samples them at E+2.
- `cmd_ready` and `level` are registered and reflect a push or pop from the edge after it.
- `busy` deasserts on the edge where the FSM enters IDLE with the FIFO empty.
- The dwell counter is DWELL_W bits wide, so the maximum dwell is 2^DWELL_W − 1 cycles with no wrap. The counter never underflows.

## Configuration
- Macro `JK_SEQ_CHECK_EN`.
- When defined:
  - An expected-Q register (reset to 0) updates at the end of each APPLY cycle: set→1, clear→0, toggle→inverted, hold→unchanged.
  - The comparison is delayed one stage: `q_fb` is compared with expected Q at the edge following the flop's sampling edge, i.e. E+3 for the example above.
  - Any inequality sets `err`; only `reset_n` clears it.
  - Back-to-back commands are each checked in pipeline order.
- When not defined:
  - `q_fb` is ignored and `err` is tied to 0.
  - No checker logic is generated.
  - Ports are identical in both builds.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles, then release → `j` = `k` = 0, `cmd_ready` = 1, `level` = 0, `busy` = 0, `err` = 0.
- Single command: push set with dwell = 2 into an empty block → `j` = 1, `k` = 0 for exactly one cycle starting at edge E+1, then 2 cycles of `j` = `k` = 0, then IDLE with `busy` = 0.
- Back-to-back: push toggle, toggle, clear, each with dwell = 0 → three consecutive single-cycle pulses J/K = 11, 11, 01 with no gap.
- Full/wrap: with DEPTH = 4, push 6 commands (dwell = 3) while `cmd_valid` is held high:
  - `cmd_ready` drops when `level` = 4 and never accepts a push while full.
  - Pulses appear in push order.
  - Pointers wrap correctly.
- Reset mid-operation: assert `reset_n` low during DWELL with 2 entries queued → outputs reset asynchronously, and no further pulses appear after release.
- Checker (`JK_SEQ_CHECK_EN`): with `jk` attached, the sequence set, toggle, toggle gives `err` = 0. Forcing `q_fb` = 0 after a set gives `err` = 1 at E+3, and it stays set.
